io_load_sequencer: RTL and testbench

IO_LOAD_SEQUENCER -- requirements
Module: io_load_sequencer

---
 rtl/io_pkg.sv | 27 ++
 rtl/io_row_assembler.sv | 56 +++++
 rtl/io_load_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_io_load_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the IO load sequencer: default parameter values and
// the sequencer FSM state encoding.
//
// Configuration macro: IO_TIMEOUT_EN adds the TIMEOUT state to the encoding.
// -----------------------------------------------------------------------------
package io_pkg;

  localparam int DEF_SECTION_SIZE   = 4;
  localparam int DEF_ROW_SIZE       = 16;
  localparam int DEF_ADDR_W         = 10;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_DECOMP  = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
`ifdef IO_TIMEOUT_EN
    ,
    ST_TIMEOUT = 3'd5
`endif
  } state_t;

endpackage : io_pkg

// File: rtl/io_row_assembler.sv
// -----------------------------------------------------------------------------
// io_row_assembler
// Shifts incoming sections into a row register (first section ends up in the
// MSBs) and counts them; flags the cycle in which the last section of a row is
// accepted.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         restart the section count (new frame)
//   accept        section valid and taken this cycle
//   section       incoming section
//   row_data      assembled row
//   row_complete  accept of the K-th section of the current row (combinational)
// -----------------------------------------------------------------------------
module io_row_assembler
  import io_pkg::*;
#(
  parameter int SECTION_SIZE = DEF_SECTION_SIZE,
  parameter int ROW_SIZE     = DEF_ROW_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    accept,
  input  logic [SECTION_SIZE-1:0] section,
  output logic [ROW_SIZE-1:0]     row_data,
  output logic                    row_complete
);

  localparam int K     = ROW_SIZE / SECTION_SIZE;
  localparam int CNT_W = $clog2(K + 1);

  logic [CNT_W-1:0] sec_cnt;

  assign row_complete = accept && (sec_cnt == CNT_W'(K - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_data <= '0;
      sec_cnt  <= '0;
    end else begin
      if (accept) begin
        row_data <= (row_data << SECTION_SIZE) | ROW_SIZE'(section);
      end
      if (clear) begin
        sec_cnt <= '0;
      end else if (accept) begin
        // Wrap on the last section so the next row starts from zero.
        sec_cnt <= row_complete ? '0 : sec_cnt + CNT_W'(1);
      end
    end
  end

endmodule : io_row_assembler

// File: rtl/io_load_sequencer.sv
// -----------------------------------------------------------------------------
// io_load_sequencer
// Collects SECTION_SIZE-bit sections into ROW_SIZE-bit compressed rows, hands
// each row to a decompressor, then writes it to row memory at consecutive
// addresses until frame_rows rows are written.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   load          level: request/hold a frame load (drop = abort)
//   cnn_img       destination select, latched at load start (-> mem_sel)
//   frame_rows    rows in the frame, latched at load start
//   interrupt     strobe: in_section valid
//   in_section    incoming section
//   decomp_done   decompressor finished strobe
//   decomp_en     one-cycle decompressor start pulse
//   row_data      assembled compressed row
//   mem_we        one-cycle row write strobe
//   mem_addr      row write address (current row count)
//   mem_sel       latched cnn_img
//   busy          not idle
//   done          frame complete, held until load drops
//   overrun       sticky: a section arrived while the row was not collecting
//   error         idle-gap timeout
//
// Configuration macro: IO_TIMEOUT_EN enables the idle-gap counter and TIMEOUT
// state; without it error is constant 0.
// -----------------------------------------------------------------------------
module io_load_sequencer
  import io_pkg::*;
#(
  parameter int SECTION_SIZE   = DEF_SECTION_SIZE,
  parameter int ROW_SIZE       = DEF_ROW_SIZE,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    cnn_img,
  input  logic [ADDR_W-1:0]       frame_rows,
  input  logic                    interrupt,
  input  logic [SECTION_SIZE-1:0] in_section,
  input  logic                    decomp_done,
  output logic                    decomp_en,
  output logic [ROW_SIZE-1:0]     row_data,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic                    error
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] row_cnt;
  logic [ADDR_W-1:0] frame_rows_q;
  logic              start;
  logic              accept;
  logic              row_complete;
  logic              last_row;

  assign start    = (state == ST_IDLE) && load;
  // Sections are only taken while collecting and the load is still held.
  assign accept   = (state == ST_COLLECT) && interrupt && load;
  assign last_row = (row_cnt == (frame_rows_q - ADDR_W'(1)));
  assign mem_addr = row_cnt;

  io_row_assembler #(
    .SECTION_SIZE (SECTION_SIZE),
    .ROW_SIZE     (ROW_SIZE)
  ) u_row_assembler (
    .clk          (clk),
    .rst          (rst),
    .clear        (start),
    .accept       (accept),
    .section      (in_section),
    .row_data     (row_data),
    .row_complete (row_complete)
  );

`ifdef IO_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             gap_expired;

  // Fires on the TIMEOUT_CYCLES-th consecutive COLLECT cycle without a section.
  assign gap_expired = (state == ST_COLLECT) && !accept &&
                       (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if ((state != ST_COLLECT) || accept) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no branch leaves a signal unassigned and no
    // latch is inferred.
    next_state = state;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    mem_we     = 1'b0;
    error      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load) begin
          next_state = (frame_rows == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (!load) begin
          next_state = ST_IDLE;
        end else if (row_complete) begin
          next_state = ST_DECOMP;
`ifdef IO_TIMEOUT_EN
        end else if (gap_expired) begin
          next_state = ST_TIMEOUT;
`endif
        end
      end
      ST_DECOMP: begin
        if (!load) begin
          next_state = ST_IDLE;
        end else if (decomp_done) begin
          next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        if (!load) begin
          next_state = ST_IDLE;
        end else if (last_row) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_COLLECT;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (!load) begin
          next_state = ST_IDLE;
        end
      end
`ifdef IO_TIMEOUT_EN
      ST_TIMEOUT: begin
        error = 1'b1;
        if (!load) begin
          next_state = ST_IDLE;
        end
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  // Frame bookkeeping and the registered decompressor start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt      <= '0;
      frame_rows_q <= '0;
      mem_sel      <= 1'b0;
      overrun      <= 1'b0;
      decomp_en    <= 1'b0;
    end else begin
      // High only in the first DECOMP cycle, never on an aborted row.
      decomp_en <= (state == ST_COLLECT) && (next_state == ST_DECOMP);
      if (start) begin
        row_cnt      <= '0;
        frame_rows_q <= frame_rows;
        mem_sel      <= cnn_img;
        overrun      <= 1'b0;
      end else begin
        if (state == ST_WRITE) begin
          row_cnt <= row_cnt + ADDR_W'(1);
        end
        if (interrupt && ((state == ST_DECOMP) || (state == ST_WRITE))) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule : io_load_sequencer

// File: tb/tb_io_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_io_load_sequencer
// Self-checking bench for io_load_sequencer: a cycle table for the reference
// two-row frame, hand-written corner sequences (abort, reset, empty frame,
// timeout) and randomized frames checked against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_io_load_sequencer;

  localparam int SECTION_SIZE   = 4;
  localparam int ROW_SIZE       = 16;
  localparam int ADDR_W         = 10;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int K              = ROW_SIZE / SECTION_SIZE;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    load;
  logic                    cnn_img;
  logic [ADDR_W-1:0]       frame_rows;
  logic                    interrupt;
  logic [SECTION_SIZE-1:0] in_section;
  logic                    decomp_done;
  logic                    decomp_en;
  logic [ROW_SIZE-1:0]     row_data;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_sel;
  logic                    busy;
  logic                    done;
  logic                    overrun;
  logic                    error;

  io_load_sequencer #(
    .SECTION_SIZE   (SECTION_SIZE),
    .ROW_SIZE       (ROW_SIZE),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .cnn_img     (cnn_img),
    .frame_rows  (frame_rows),
    .interrupt   (interrupt),
    .in_section  (in_section),
    .decomp_done (decomp_done),
    .decomp_en   (decomp_en),
    .row_data    (row_data),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_sel     (mem_sel),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .error       (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int den_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sec(input logic [SECTION_SIZE-1:0] s);
    interrupt  = 1'b1;
    in_section = s;
    tick();
    interrupt  = 1'b0;
  endtask

  // Counts write and start pulses independently of the driving code.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_we === 1'b1) we_cnt++;
      if (decomp_en === 1'b1) den_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Cycle table for the reference two-row frame
  // ---------------------------------------------------------------------------
  typedef struct {
    logic                    load;
    logic                    cnn;
    logic [ADDR_W-1:0]       fr;
    logic                    intr;
    logic [SECTION_SIZE-1:0] sec;
    logic                    dd;
    logic                    e_busy;
    logic                    e_done;
    logic                    e_den;
    logic                    e_we;
    logic [ADDR_W-1:0]       e_addr;
    logic                    e_sel;
    logic                    chk_row;
    logic [ROW_SIZE-1:0]     e_row;
  } vec_t;

  vec_t vt[$];

  function automatic void add_vec(input logic ld, input logic it, input logic [3:0] sc,
                                  input logic dd, input logic eb, input logic edn,
                                  input logic eden, input logic ewe, input int ea,
                                  input logic cr, input logic [15:0] er);
    vec_t v;
    v.load = ld;  v.cnn = 1'b1; v.fr = ADDR_W'(2);
    v.intr = it;  v.sec = sc;   v.dd = dd;
    v.e_busy = eb; v.e_done = edn; v.e_den = eden; v.e_we = ewe;
    v.e_addr = ADDR_W'(ea); v.e_sel = 1'b1; v.chk_row = cr; v.e_row = er;
    vt.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Randomized frame against a transaction-level model: each row is the
  // concatenation of its K sections, written at addresses 0..rows-1.
  // inj: 0 none, 1 stray section during DECOMP, 2 stray section during WRITE.
  // ---------------------------------------------------------------------------
  task automatic run_frame(input int rows, input bit cnn, input int inj);
    logic [ROW_SIZE-1:0]     exp_row;
    logic [SECTION_SIZE-1:0] s;
    bit                      exp_ovr = 1'b0;
    int                      we0 = we_cnt;
    int                      den0 = den_cnt;
    int                      dly;
    load = 1'b1; cnn_img = cnn; frame_rows = ADDR_W'(rows);
    tick();
    check("rf_start_busy", busy, 1);
    check("rf_start_sel", mem_sel, cnn);
    check("rf_start_addr", mem_addr, 0);
    check("rf_start_ovr", overrun, 0);
    for (int r = 0; r < rows; r++) begin
      exp_row = '0;
      for (int k = 0; k < K; k++) begin
        repeat ($urandom_range(0, 3)) begin
          decomp_done = 1'($urandom_range(0, 1));   // must be ignored outside DECOMP
          tick();
        end
        decomp_done = 1'b0;
        s = SECTION_SIZE'($urandom_range(0, 15));
        send_sec(s);
        exp_row = (exp_row << SECTION_SIZE) | ROW_SIZE'(s);
        if (k < K - 1) check("rf_no_early_den", decomp_en, 0);
      end
      check("rf_den_pulse", decomp_en, 1);
      dly = $urandom_range((inj == 1) ? 1 : 0, 4);
      for (int c = 0; c < dly; c++) begin
        if (inj == 1 && c == 0) begin
          interrupt = 1'b1; in_section = '1; exp_ovr = 1'b1;
        end
        tick();
        interrupt = 1'b0;
        check("rf_den_single", decomp_en, 0);
        check("rf_no_early_we", mem_we, 0);
      end
      decomp_done = 1'b1;
      tick();
      decomp_done = 1'b0;
      check("rf_we", mem_we, 1);
      check("rf_addr", mem_addr, r);
      check("rf_row", row_data, exp_row);
      if (inj == 2) begin
        interrupt = 1'b1; in_section = '1; exp_ovr = 1'b1;
      end
      tick();
      interrupt = 1'b0;
      check("rf_we_single", mem_we, 0);
    end
    check("rf_done", done, 1);
    check("rf_ovr", overrun, exp_ovr);
    check("rf_end_addr", mem_addr, rows);
    load = 1'b0;
    tick();
    check("rf_idle_done", done, 0);
    check("rf_idle_busy", busy, 0);
    check("rf_we_count", we_cnt - we0, rows);
    check("rf_den_count", den_cnt - den0, rows);
  endtask

  initial begin
    int we0;
    rst = 1'b1; load = 1'b0; cnn_img = 1'b0; frame_rows = '0;
    interrupt = 1'b0; in_section = '0; decomp_done = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_den", decomp_en, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_row", row_data, 0);
    check("rst_sel", mem_sel, 0);
    check("rst_ovr", overrun, 0);
    check("rst_err", error, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reference frame: rows 0xABCD, 0x1234; decomp_done 3 cycles after decomp_en
    //      ld it sec  dd  busy done den we addr chk row
    add_vec(1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
    add_vec(1, 1, 4'hA, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
    add_vec(1, 1, 4'hB, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
    add_vec(1, 1, 4'hC, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
    add_vec(1, 1, 4'hD, 0, 1, 0, 1, 0, 0, 1, 16'hABCD);
    add_vec(1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
    add_vec(1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
    add_vec(1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 16'h0000);
    add_vec(1, 0, 4'h0, 1, 1, 0, 0, 1, 0, 1, 16'hABCD);
    add_vec(1, 0, 4'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0000);
    add_vec(1, 1, 4'h1, 0, 1, 0, 0, 0, 1, 0, 16'h0000);
    add_vec(1, 1, 4'h2, 0, 1, 0, 0, 0, 1, 0, 16'h0000);
    add_vec(1, 1, 4'h3, 0, 1, 0, 0, 0, 1, 0, 16'h0000);
    add_vec(1, 1, 4'h4, 0, 1, 0, 1, 0, 1, 1, 16'h1234);
    add_vec(1, 0, 4'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0000);
    add_vec(1, 0, 4'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0000);
    add_vec(1, 0, 4'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0000);
    add_vec(1, 0, 4'h0, 1, 1, 0, 0, 1, 1, 1, 16'h1234);
    add_vec(1, 0, 4'h0, 0, 1, 1, 0, 0, 2, 0, 16'h0000);
    add_vec(1, 0, 4'h0, 0, 1, 1, 0, 0, 2, 0, 16'h0000);
    add_vec(0, 0, 4'h0, 0, 0, 0, 0, 0, 2, 0, 16'h0000);
    for (int i = 0; i < vt.size(); i++) begin
      load = vt[i].load; cnn_img = vt[i].cnn; frame_rows = vt[i].fr;
      interrupt = vt[i].intr; in_section = vt[i].sec; decomp_done = vt[i].dd;
      tick();
      check($sformatf("tbl%0d_busy", i), busy, vt[i].e_busy);
      check($sformatf("tbl%0d_done", i), done, vt[i].e_done);
      check($sformatf("tbl%0d_den", i), decomp_en, vt[i].e_den);
      check($sformatf("tbl%0d_we", i), mem_we, vt[i].e_we);
      check($sformatf("tbl%0d_addr", i), mem_addr, vt[i].e_addr);
      check($sformatf("tbl%0d_sel", i), mem_sel, vt[i].e_sel);
      check($sformatf("tbl%0d_ovr", i), overrun, 0);
      if (vt[i].chk_row) check($sformatf("tbl%0d_row", i), row_data, vt[i].e_row);
    end
    interrupt = 1'b0; decomp_done = 1'b0;

    // Empty frame goes straight to DONE
    load = 1'b1; cnn_img = 1'b0; frame_rows = '0;
    tick();
    check("empty_done", done, 1);
    check("empty_we", mem_we, 0);
    check("empty_sel", mem_sel, 0);
    load = 1'b0;
    tick();
    check("empty_idle", busy, 0);

    // Abort in the middle of the second row, then restart from address 0
    we0 = we_cnt;
    load = 1'b1; cnn_img = 1'b0; frame_rows = ADDR_W'(2);
    tick();
    send_sec(4'h1); send_sec(4'h2); send_sec(4'h3); send_sec(4'h4);
    tick();
    decomp_done = 1'b1;
    tick();
    decomp_done = 1'b0;
    check("abort_row0_we", mem_we, 1);
    tick();
    send_sec(4'h5); send_sec(4'h6);
    load = 1'b0;
    tick();
    check("abort_busy", busy, 0);
    check("abort_den", decomp_en, 0);
    check("abort_we", mem_we, 0);
    repeat (2) tick();
    check("abort_we_count", we_cnt - we0, 1);
    run_frame(2, 1'b0, 0);

    // Stray section in DECOMP: overrun set, following row unaffected
    run_frame(2, 1'b1, 1);
    run_frame(1, 1'b0, 2);

    // Randomized frames
    repeat (6) run_frame($urandom_range(1, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 2));

    // Asynchronous reset in the middle of DECOMP
    load = 1'b1; cnn_img = 1'b1; frame_rows = ADDR_W'(1);
    tick();
    send_sec(4'h9); send_sec(4'h8); send_sec(4'h7);
    send_sec(4'h6);
    check("rdec_den", decomp_en, 1);
    send_sec(4'hF);
    check("rdec_ovr", overrun, 1);
    check("rdec_row", row_data, 16'h9876);
    we0 = we_cnt;
    #2;
    rst = 1'b1;
    #1;
    check("rdec_busy", busy, 0);
    check("rdec_done", done, 0);
    check("rdec_den0", decomp_en, 0);
    check("rdec_we", mem_we, 0);
    check("rdec_addr", mem_addr, 0);
    check("rdec_row0", row_data, 0);
    check("rdec_sel", mem_sel, 0);
    check("rdec_ovr0", overrun, 0);
    check("rdec_err", error, 0);
    load = 1'b0;
    #3;
    rst = 1'b0;
    tick();
    decomp_done = 1'b1;
    tick();
    decomp_done = 1'b0;
    check("rdec_ignored_we", mem_we, 0);
    check("rdec_ignored_busy", busy, 0);
    tick();
    check("rdec_we_count", we_cnt - we0, 0);

    // Idle gap in COLLECT
    load = 1'b1; frame_rows = ADDR_W'(1);
    tick();
    repeat (TIMEOUT_CYCLES - 1) tick();
    check("gap_err_early", error, 0);
    tick();
`ifdef IO_TIMEOUT_EN
    check("gap_err", error, 1);
    repeat (3) tick();
    check("gap_err_hold", error, 1);
`else
    check("gap_err", error, 0);
    repeat (3) tick();
    check("gap_err_hold", error, 0);
`endif
    check("gap_busy", busy, 1);
    load = 1'b0;
    tick();
    check("gap_err_clear", error, 0);
    check("gap_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_io_load_sequencer
